// File: rtl/dll_shift_scheduler_pkg.sv
// Shared widths, limits and tag range helper for the DLL shift scheduler.
package dll_shift_scheduler_pkg;

    // Widths inherited from the DLL and channel blocks.
    localparam int CHANNEL_ID_WIDTH    = 4;
    localparam int DLL_SHIFT_WIDTH     = 8;

    // Scheduler defaults.
    localparam int DLL_SCHED_NUM_CHAN  = 16;
    localparam int DLL_SCHED_ACC_WIDTH = 10;   // must be >= DLL_SHIFT_WIDTH+2
    localparam int DLL_SCHED_SAT_MAX   = 300;  // must be < 2**(ACC_WIDTH-1)

    // True when a tag addresses a real channel entry.
    function automatic logic tag_in_range(input int tag, input int num_chan);
        return (tag >= 0) && (tag < num_chan);
    endfunction

endpackage

// File: rtl/dll_shift_scheduler_sat_add.sv
// Combinational signed add with symmetric clamp to +/-SAT_MAX.
// The sum is formed one bit wider than the operands so it can never wrap
// before the clamp decision is made.
module dll_sat_add
    import dll_shift_scheduler_pkg::*;
#(
    parameter int ACC_W   = DLL_SCHED_ACC_WIDTH,
    parameter int SAT_MAX = DLL_SCHED_SAT_MAX
) (
    input  logic signed [ACC_W-1:0] i_a,
    input  logic signed [ACC_W-1:0] i_b,
    output logic signed [ACC_W-1:0] o_sum,
    output logic                    o_clamp_active
);

    localparam logic signed [ACC_W:0] L_POS = (ACC_W+1)'(SAT_MAX);
    localparam logic signed [ACC_W:0] L_NEG = -L_POS;

    logic signed [ACC_W:0] w_wide;

    // Widen, add, then clamp to the symmetric ceiling.
    always_comb begin
        w_wide         = {i_a[ACC_W-1], i_a} + {i_b[ACC_W-1], i_b};
        o_sum          = w_wide[ACC_W-1:0];
        o_clamp_active = 1'b0;
        if (w_wide > L_POS) begin
            o_sum          = L_POS[ACC_W-1:0];
            o_clamp_active = 1'b1;
        end else if (w_wide < L_NEG) begin
            o_sum          = L_NEG[ACC_W-1:0];
            o_clamp_active = 1'b1;
        end
    end

endmodule

// File: rtl/dll_shift_scheduler.sv
// Per-channel pending-shift store between the DLL and the code generators.
// Each DLL result is folded into its channel's saturating accumulator; a
// channel's apply request returns the accumulated shift (sign/magnitude) one
// cycle later and clears the entry.
// Handshake: apply_req/apply_req_tag are sampled on a rising edge; the
// response (apply_valid plus fields) is registered and held for exactly the
// following cycle. Every request with reset low gets exactly one response;
// there is no back-pressure, so one request per cycle is accepted.
module dll_shift_scheduler
    import dll_shift_scheduler_pkg::*;
#(
    parameter int NUM_CHAN = DLL_SCHED_NUM_CHAN,
    parameter int CHAN_W   = CHANNEL_ID_WIDTH,
    parameter int SHIFT_W  = DLL_SHIFT_WIDTH,
    parameter int ACC_W    = DLL_SCHED_ACC_WIDTH,
    parameter int SAT_MAX  = DLL_SCHED_SAT_MAX
) (
    input  logic               clk,
    input  logic               global_reset,
    input  logic               result_ready,
    input  logic [CHAN_W-1:0]  result_tag,
    input  logic               shift_direction,
    input  logic [SHIFT_W-1:0] shift_amount,
    input  logic               flush,
    input  logic [CHAN_W-1:0]  flush_tag,
    input  logic               apply_req,
    input  logic [CHAN_W-1:0]  apply_req_tag,
    output logic               apply_valid,
    output logic [CHAN_W-1:0]  apply_tag,
    output logic               apply_dir,
    output logic [ACC_W-2:0]   apply_amount,
    output logic               apply_pending,
    output logic               apply_sat
);

    // Entry storage: flops, so a read and a write of one tag can share a cycle.
    logic signed [ACC_W-1:0] r_acc [NUM_CHAN];
    logic [NUM_CHAN-1:0]     r_pend;
    logic [NUM_CHAN-1:0]     r_sat;

    logic                    r_apply_valid;
    logic [CHAN_W-1:0]       r_apply_tag;
    logic                    r_apply_dir;
    logic [ACC_W-2:0]        r_apply_amount;
    logic                    r_apply_pending;
    logic                    r_apply_sat;

    logic                    w_res_hit;
    logic                    w_app_hit;
    logic                    w_app_flushed;
    logic                    w_same_tag;
    logic [ACC_W-1:0]        w_amt_ext;
    logic signed [ACC_W-1:0] w_delta;
    logic signed [ACC_W-1:0] w_res_cur_acc;
    logic signed [ACC_W-1:0] w_add_a;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_clamp;
    logic signed [ACC_W-1:0] w_app_acc;
    logic                    w_app_pend;
    logic                    w_app_sat;
    logic [ACC_W-2:0]        w_app_mag;

    // Qualify the three request ports; a flush of the same tag kills the result.
    always_comb begin
        w_app_hit     = apply_req && tag_in_range(int'(apply_req_tag), NUM_CHAN);
        w_app_flushed = flush && (flush_tag == apply_req_tag);
        w_res_hit     = result_ready && tag_in_range(int'(result_tag), NUM_CHAN)
                        && !(flush && (flush_tag == result_tag));
        w_same_tag    = w_app_hit && (apply_req_tag == result_tag);
        w_amt_ext     = {{(ACC_W-SHIFT_W){1'b0}}, shift_amount};
        w_delta       = shift_direction ? -$signed(w_amt_ext) : $signed(w_amt_ext);
    end

    // Read muxes for the result and apply tags (out-of-range reads give zero).
    always_comb begin
        w_res_cur_acc = '0;
        w_app_acc     = '0;
        w_app_pend    = 1'b0;
        w_app_sat     = 1'b0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (result_tag == CHAN_W'(i)) begin
                w_res_cur_acc = r_acc[i];
            end
            if (apply_req_tag == CHAN_W'(i)) begin
                w_app_acc  = r_acc[i];
                w_app_pend = r_pend[i];
                w_app_sat  = r_sat[i];
            end
        end
    end

    // A result landing on an entry that is being read this cycle starts from zero.
    always_comb begin
        w_add_a   = w_same_tag ? '0 : w_res_cur_acc;
        w_app_mag = w_app_acc[ACC_W-1] ? (ACC_W-1)'(-w_app_acc) : w_app_acc[ACC_W-2:0];
    end

    dll_sat_add #(
        .ACC_W   (ACC_W),
        .SAT_MAX (SAT_MAX)
    ) u_sat_add (
        .i_a            (w_add_a),
        .i_b            (w_delta),
        .o_sum          (w_sum),
        .o_clamp_active (w_clamp)
    );

    // Entry update: flush beats result, result beats a plain read-clear.
    always_ff @(posedge clk) begin
        if (global_reset) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                r_acc[i]  <= '0;
                r_pend[i] <= 1'b0;
                r_sat[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                if (flush && (flush_tag == CHAN_W'(i))) begin
                    r_acc[i]  <= '0;
                    r_pend[i] <= 1'b0;
                    r_sat[i]  <= 1'b0;
                end else if (w_res_hit && (result_tag == CHAN_W'(i))) begin
                    r_acc[i]  <= w_sum;
                    r_pend[i] <= 1'b1;
                    r_sat[i]  <= (w_same_tag ? 1'b0 : r_sat[i]) | w_clamp;
                end else if (w_app_hit && (apply_req_tag == CHAN_W'(i))) begin
                    r_acc[i]  <= '0;
                    r_pend[i] <= 1'b0;
                    r_sat[i]  <= 1'b0;
                end
            end
        end
    end

    // Registered response: pre-clear contents, or zeros for flushed/invalid tags.
    always_ff @(posedge clk) begin
        if (global_reset || !apply_req) begin
            r_apply_valid   <= 1'b0;
            r_apply_tag     <= '0;
            r_apply_dir     <= 1'b0;
            r_apply_amount  <= '0;
            r_apply_pending <= 1'b0;
            r_apply_sat     <= 1'b0;
        end else begin
            r_apply_valid <= 1'b1;
            r_apply_tag   <= apply_req_tag;
            if (w_app_hit && !w_app_flushed) begin
                r_apply_dir     <= w_app_acc[ACC_W-1];
                r_apply_amount  <= w_app_mag;
                r_apply_pending <= w_app_pend;
                r_apply_sat     <= w_app_sat;
            end else begin
                r_apply_dir     <= 1'b0;
                r_apply_amount  <= '0;
                r_apply_pending <= 1'b0;
                r_apply_sat     <= 1'b0;
            end
        end
    end

    assign apply_valid   = r_apply_valid;
    assign apply_tag     = r_apply_tag;
    assign apply_dir     = r_apply_dir;
    assign apply_amount  = r_apply_amount;
    assign apply_pending = r_apply_pending;
    assign apply_sat     = r_apply_sat;

endmodule
